inst_axi_rd_bridge: RTL and testbench

Instruction-side bridge between the IF stage's sram-like fetch port and an AXI3/4 read master interface. It accepts one fetch request at a time on the `inst_sram_*` handshake and issues it as a single-beat AXI read. It returns the instruction word with a registered one-cycle `data_ok` pulse. The IF stage connects directly to it; the AXI side goes to the crossbar / memory model.

---
 rtl/inst_axi_rd_bridge_if.sv | 37 +++
 rtl/inst_axi_rd_bridge.sv | 100 ++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_rd_bridge_if.sv
// AXI3/4 read-address and read-data channels used by inst_axi_rd_bridge.
//   master : the bridge side (drives AR payload/valid and rready)
//   slave  : the crossbar / memory side (drives arready and the R payload/valid)
interface inst_axi_rd_bridge_if;
  // AR channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // R channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch bridge: sram-like fetch port -> single-beat AXI read.
// One fetch is outstanding at a time; each accepted request (addr_ok) is
// answered by exactly one registered data_ok pulse carrying the word and an
// error flag derived from rresp.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   inst_sram_req/addr/size fetch request (wr/wstrb/wdata are ignored)
//   inst_sram_addr_ok      request accepted (combinational, IDLE only)
//   inst_sram_data_ok      one-cycle pulse, rdata/rd_err valid
//   inst_sram_rdata        returned instruction word (holds last value)
//   inst_rd_err            rresp was nonzero for the returned word
//   axi                    AXI read master (AR + R channels)
module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        inst_sram_req,
  input  logic                        inst_sram_wr,
  input  logic [1:0]                  inst_sram_size,
  input  logic [3:0]                  inst_sram_wstrb,
  input  logic [31:0]                 inst_sram_addr,
  input  logic [31:0]                 inst_sram_wdata,
  output logic                        inst_sram_addr_ok,
  output logic                        inst_sram_data_ok,
  output logic [31:0]                 inst_sram_rdata,
  output logic                        inst_rd_err,
  inst_axi_rd_bridge_if.master        axi
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] araddr_reg;
  logic [1:0]  size_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  // Write side and the R-channel id/last are meaningless for a single
  // outstanding single-beat read; fold them into a sink.
  logic unused_ok;
  assign unused_ok = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                       axi.rid, axi.rlast, 1'b0};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      araddr_reg <= 32'h0;
      size_reg   <= 2'b00;
      rdata_reg  <= 32'h0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Request payload is captured at acceptance so the IF stage may move on.
      if (state_reg == IDLE && inst_sram_req) begin
        araddr_reg <= inst_sram_addr;
        size_reg   <= inst_sram_size;
      end
      if (state_reg == R && axi.rvalid) begin
        rdata_reg <= axi.rdata;
        err_reg   <= (axi.rresp != 2'b00);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (inst_sram_req) state_next = AR;
      AR:   if (axi.arready)   state_next = R;
      R:    if (axi.rvalid)    state_next = DONE;
      DONE:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so arready never reaches rready
  // combinationally; only addr_ok looks at an input.
  assign inst_sram_addr_ok = (state_reg == IDLE) && inst_sram_req;
  assign inst_sram_data_ok = (state_reg == DONE);
  assign inst_sram_rdata   = rdata_reg;
  assign inst_rd_err       = err_reg;

  assign axi.arid    = ARID_VAL;
  assign axi.araddr  = araddr_reg;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = {1'b0, size_reg};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = (state_reg == AR);
  assign axi.rready  = (state_reg == R);

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
module tb_inst_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        rd_err;

  int check_cnt = 0;
  int pass_cnt  = 0;

  inst_axi_rd_bridge_if axi_if ();

  inst_axi_rd_bridge #(.ARID_VAL(4'd0)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (req),
    .inst_sram_wr      (wr),
    .inst_sram_size    (size),
    .inst_sram_wstrb   (wstrb),
    .inst_sram_addr    (addr),
    .inst_sram_wdata   (wdata),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata),
    .inst_rd_err       (rd_err),
    .axi               (axi_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // Called at a negedge. Runs one fetch against a slave that stalls AR for
  // ar_dly cycles and R for r_dly cycles; returns at a negedge.
  task automatic fetch(input string tag, input logic [31:0] a, input int ar_dly,
                       input int r_dly, input logic [31:0] d, input logic [1:0] resp,
                       input int exp_lat, input logic exp_err);
    int acc = -1, dok_at = -1, dok_n = 0, ar_cnt = 0, r_cnt = 0, post = 0, lat;
    logic stable = 1'b1;
    logic [31:0] got = 32'h0;
    logic gerr = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      req  = (acc < 0);
      addr = (acc < 0) ? a : 32'hffff_fff0;
      size = 2'b10;
      axi_if.arready = axi_if.arvalid && (ar_cnt == ar_dly);
      axi_if.rvalid  = axi_if.rready && (r_cnt == r_dly);
      axi_if.rdata   = axi_if.rvalid ? d : 32'h0bad0bad;
      axi_if.rresp   = axi_if.rvalid ? resp : 2'b11;
      #1;
      if (axi_if.arvalid && !axi_if.arready) ar_cnt++;
      if (axi_if.rready && !axi_if.rvalid) r_cnt++;
      if (acc < 0 && addr_ok) acc = cyc;
      if (axi_if.arvalid && (axi_if.araddr !== a || axi_if.arsize !== 3'b010)) stable = 1'b0;
      if (data_ok) begin
        dok_n++;
        if (dok_at < 0) begin
          dok_at = cyc;
          got    = rdata;
          gerr   = rd_err;
        end
      end
      if (dok_at >= 0) post++;
      @(negedge clk);
      if (post >= 4) break;
    end
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    req = 1'b0;
    lat = (acc < 0 || dok_at < 0) ? -1 : dok_at - acc;
    $display("%s: addr=0x%08h acc_cyc=%0d lat=%0d rdata=0x%08h err=%0b data_ok_count=%0d",
             tag, a, acc, lat, got, gerr, dok_n);
    check({tag, "_acc"},    32'(acc),    32'd0);
    check({tag, "_lat"},    32'(lat),    32'(exp_lat));
    check({tag, "_ndok"},   32'(dok_n),  32'd1);
    check({tag, "_rdata"},  got,         d);
    check({tag, "_err"},    32'(gerr),   32'(exp_err));
    check({tag, "_stable"}, 32'(stable), 32'd1);
    check({tag, "_hold"},   rdata,       d);
  endtask

  // Back-to-back fetches with req held high; slave answers at once.
  task automatic back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] dtab  [3];
    int acc_cyc [3];
    int acc_i = 0, ar_i = 0, r_i = 0, d_i = 0, bad = 0;
    addrs = '{32'h1c00_0000, 32'h1c00_0004, 32'h1c00_0008};
    dtab  = '{32'haaaa_0000, 32'hbbbb_1111, 32'hcccc_2222};
    acc_cyc = '{-100, -100, -100};
    for (int cyc = 0; cyc < 40 && d_i < 3; cyc++) begin
      req  = (acc_i < 3);
      addr = (acc_i < 3) ? addrs[acc_i] : 32'h0;
      size = 2'b10;
      axi_if.arready = axi_if.arvalid;
      axi_if.rvalid  = axi_if.rready;
      axi_if.rdata   = (axi_if.rvalid && r_i < 3) ? dtab[r_i] : 32'h0bad0bad;
      axi_if.rresp   = 2'b00;
      #1;
      if (addr_ok) begin
        if (axi_if.arvalid || axi_if.rready || data_ok) bad++;
        if (acc_i < 3) acc_cyc[acc_i] = cyc;
        acc_i++;
      end
      if (axi_if.arvalid && axi_if.arready) begin
        if (ar_i < 3) check($sformatf("b2b_araddr%0d", ar_i), axi_if.araddr, addrs[ar_i]);
        ar_i++;
      end
      if (axi_if.rvalid && axi_if.rready) r_i++;
      if (data_ok) begin
        $display("b2b: data_ok #%0d at cyc %0d rdata=0x%08h", d_i, cyc, rdata);
        if (d_i < 3) check($sformatf("b2b_rdata%0d", d_i), rdata, dtab[d_i]);
        d_i++;
      end
      @(negedge clk);
    end
    req = 1'b0;
    axi_if.arready = 1'b0;
    axi_if.rvalid  = 1'b0;
    check("b2b_ndok",   32'(d_i), 32'd3);
    check("b2b_space1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    check("b2b_space2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    check("b2b_bad_ok", 32'(bad), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; wstrb = 4'h0;
    addr = 32'h0; wdata = 32'h0;
    axi_if.arready = 1'b0; axi_if.rid = 4'h0; axi_if.rdata = 32'h0;
    axi_if.rresp = 2'b00; axi_if.rlast = 1'b1; axi_if.rvalid = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    $display("reset: arvalid=%0b rready=%0b data_ok=%0b rdata=0x%08h", axi_if.arvalid,
             axi_if.rready, data_ok, rdata);
    check("rst_arvalid", 32'(axi_if.arvalid), 32'd0);
    check("rst_rready",  32'(axi_if.rready),  32'd0);
    check("rst_data_ok", 32'(data_ok),        32'd0);
    check("rst_err",     32'(rd_err),         32'd0);
    check("rst_rdata",   rdata,               32'h0);
    check("rst_araddr",  axi_if.araddr,       32'h0);
    check("rst_arsize",  32'(axi_if.arsize),  32'd0);
    check("rst_addr_ok", 32'(addr_ok),        32'd0);
    check("const_ar", {axi_if.arid, axi_if.arlen, axi_if.arburst, axi_if.arlock,
                       axi_if.arcache, axi_if.arprot, 9'd0},
                      {4'h0, 8'h00, 2'b01, 2'b00, 4'h0, 3'b000, 9'd0});
    resetn = 1'b1;
    @(negedge clk);

    fetch("single", 32'h1c00_0000, 0, 0, 32'h02bf_fc0c, 2'b00, 3, 1'b0);
    fetch("stall",  32'h1c00_0040, 3, 5, 32'h1234_5678, 2'b00, 11, 1'b0);
    back_to_back();
    fetch("err",    32'h1c00_0080, 0, 0, 32'hdead_beef, 2'b10, 3, 1'b1);
    fetch("after_err", 32'h1c00_0084, 1, 2, 32'h0000_0013, 2'b00, 6, 1'b0);

    // Reset while the FSM waits in R.
    @(negedge clk);
    req = 1'b1; addr = 32'h1c00_0100; size = 2'b10;
    #1 check("rir_acc", 32'(addr_ok), 32'd1);
    @(negedge clk);
    req = 1'b0; axi_if.arready = 1'b1;
    #1 check("rir_arvalid", 32'(axi_if.arvalid), 32'd1);
    @(negedge clk);
    axi_if.arready = 1'b0; axi_if.rvalid = 1'b0;
    #1 check("rir_in_r", 32'(axi_if.rready), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    $display("reset_in_r: rready=%0b arvalid=%0b data_ok=%0b rdata=0x%08h", axi_if.rready,
             axi_if.arvalid, data_ok, rdata);
    check("rir_rready",  32'(axi_if.rready),  32'd0);
    check("rir_arvalid0", 32'(axi_if.arvalid), 32'd0);
    check("rir_data_ok", 32'(data_ok),        32'd0);
    check("rir_rdata",   rdata,               32'h0);
    check("rir_err",     32'(rd_err),         32'd0);
    check("rir_araddr",  axi_if.araddr,       32'h0);
    fetch("post_rst", 32'h1c00_0200, 0, 0, 32'h0000_abcd, 2'b00, 3, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", check_cnt);
    $fatal(1, "timeout");
  end

endmodule
